// File: rtl/mem_pkg.sv
// Shared constants for the MemPortIo request/response path: function and
// access-type codes, FSM state encodings and the request record.
package mem_pkg;

    // Memory function codes carried on req_fcn
    localparam logic M_XRD = 1'b0;
    localparam logic M_XWR = 1'b1;

    // Memory access types carried on req_typ
    localparam logic [2:0] MT_B  = 3'd1;
    localparam logic [2:0] MT_H  = 3'd2;
    localparam logic [2:0] MT_W  = 3'd3;
    localparam logic [2:0] MT_BU = 3'd5;
    localparam logic [2:0] MT_HU = 3'd6;

    // Responder FSM states
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    // Captured request
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        fcn;
        logic [2:0]  typ;
    } mem_req_t;

    // Map unsupported type codes (0, 4, 7) onto a full-word access
    function automatic logic [2:0] norm_typ(input logic [2:0] typ);
        logic [2:0] res;
        case (typ)
            MT_B, MT_H, MT_BU, MT_HU: res = typ;
            default:                  res = MT_W;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering for a 32-bit word memory: builds store data and
// byte enables, extracts and extends load data, and flags misaligned accesses.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [2:0]  typ,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] st_data,
    input  logic [31:0] rword,
    output logic [31:0] wdata,
    output logic [3:0]  wmask,
    output logic [31:0] rdata,
    output logic        misaligned
);

    logic [2:0]  typ_n;
    logic [31:0] byte_shift;
    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    assign typ_n = norm_typ(typ);

    // Store path: replicate data across the word, enable only the addressed lane
    always_comb begin
        wdata = st_data;
        wmask = 4'b1111;
        case (typ_n)
            MT_B, MT_BU: begin
                wdata = {4{st_data[7:0]}};
                wmask = 4'b0001 << addr_lo;
            end
            MT_H, MT_HU: begin
                wdata = {2{st_data[15:0]}};
                wmask = addr_lo[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                wdata = st_data;
                wmask = 4'b1111;
            end
        endcase
    end

    assign byte_shift = rword >> {addr_lo, 3'b000};
    assign rbyte      = byte_shift[7:0];
    assign rhalf      = addr_lo[1] ? rword[31:16] : rword[15:0];

    // Load path: select the addressed lane and sign- or zero-extend it
    always_comb begin
        rdata = rword;
        case (typ_n)
            MT_B:    rdata = {{24{rbyte[7]}}, rbyte};
            MT_BU:   rdata = {24'h000000, rbyte};
            MT_H:    rdata = {{16{rhalf[15]}}, rhalf};
            MT_HU:   rdata = {16'h0000, rhalf};
            default: rdata = rword;
        endcase
    end

    // Halfwords need an even address, words a 4-byte-aligned one
    always_comb begin
        misaligned = 1'b0;
        case (typ_n)
            MT_H, MT_HU: misaligned = addr_lo[0];
            MT_W:        misaligned = (addr_lo != 2'b00);
            default:     misaligned = 1'b0;
        endcase
    end

endmodule

// File: rtl/scratchpad_mem_responder.sv
// Word-organised scratchpad answering MemPortIo requests with a fixed access
// latency and a single outstanding request. The array is read and written on
// the clock edge that enters RESP, so resp_valid is a one-cycle pulse that
// lines up with the registered load result.
module scratchpad_mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH   = 1024,  // words, power of two, >= 2
    parameter int unsigned LATENCY = 1      // >= 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_data,
    input  logic        req_fcn,
    input  logic [2:0]  req_typ,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        resp_misaligned
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(LATENCY) + 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((LATENCY >= 2) ? (LATENCY - 2) : 0);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    mem_req_t         req_q;
    mem_req_t         req_live;
    mem_req_t         req_cur;

    logic             accept;
    logic             enter_resp;
    logic [AW-1:0]    idx;
    logic [31:0]      rword;
    logic [31:0]      wdata;
    logic [3:0]       wmask;
    logic [31:0]      rdata;
    logic             misaligned;
    logic [31:0]      resp_data_q;
    logic             resp_mis_q;

    logic [31:0]      mem [DEPTH];

    // Address bits above the word index are deliberately ignored (wrap)
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[31:AW+2];

    assign req_ready = !reset && (state_q == IDLE || state_q == RESP);
    assign accept    = req_valid && req_ready;

    assign req_live = '{addr: req_addr, data: req_data, fcn: req_fcn, typ: req_typ};

    // With single-cycle latency the access edge is the accept edge itself,
    // so the live request is used; otherwise the captured one.
    assign req_cur = (LATENCY == 1) ? req_live : req_q;

    // Next-state and latency-counter logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE, RESP: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_d = RESP;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = CNT_INIT;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign enter_resp = (state_d == RESP);

    // FSM, counter and request capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                req_q <= req_live;
            end
        end
    end

    assign idx   = req_cur.addr[AW+1:2];
    assign rword = mem[idx];

    mem_lane_align u_lane_align (
        .typ        (req_cur.typ),
        .addr_lo    (req_cur.addr[1:0]),
        .st_data    (req_cur.data),
        .rword      (rword),
        .wdata      (wdata),
        .wmask      (wmask),
        .rdata      (rdata),
        .misaligned (misaligned)
    );

    // Byte-enabled store commit on the edge entering RESP; contents not reset
    always_ff @(posedge clk) begin
        if (enter_resp && !reset && req_cur.fcn == M_XWR && !misaligned) begin
            for (int i = 0; i < 4; i++) begin
                if (wmask[i]) begin
                    mem[idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // Response registers, held until the next response
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_data_q <= '0;
            resp_mis_q  <= 1'b0;
        end else if (enter_resp) begin
            resp_mis_q  <= misaligned;
            resp_data_q <= (misaligned || req_cur.fcn == M_XWR) ? 32'h0 : rdata;
        end
    end

    assign resp_valid      = (state_q == RESP);
    assign resp_data       = resp_data_q;
    assign resp_misaligned = resp_mis_q;

endmodule

// File: tb/tb_scratchpad_mem_responder.sv
// Directed bench: one responder with LATENCY=1 and one with LATENCY=3.
module tb_scratchpad_mem_responder;
    import mem_pkg::*;

    logic clk;
    logic rst1, rst3;

    logic        v1, f1, rdy1, rv1, rm1;
    logic [2:0]  t1;
    logic [31:0] a1, d1, rd1;

    logic        v3, f3, rdy3, rv3, rm3;
    logic [2:0]  t3;
    logic [31:0] a3, d3, rd3;

    int errors = 0;
    int checks = 0;

    scratchpad_mem_responder #(.DEPTH(1024), .LATENCY(1)) dut1 (
        .clk             (clk),
        .reset           (rst1),
        .req_valid       (v1),
        .req_ready       (rdy1),
        .req_addr        (a1),
        .req_data        (d1),
        .req_fcn         (f1),
        .req_typ         (t1),
        .resp_valid      (rv1),
        .resp_data       (rd1),
        .resp_misaligned (rm1)
    );

    scratchpad_mem_responder #(.DEPTH(1024), .LATENCY(3)) dut3 (
        .clk             (clk),
        .reset           (rst3),
        .req_valid       (v3),
        .req_ready       (rdy3),
        .req_addr        (a3),
        .req_data        (d3),
        .req_fcn         (f3),
        .req_typ         (t3),
        .resp_valid      (rv3),
        .resp_data       (rd3),
        .resp_misaligned (rm3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "bench did not finish");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One request on the LATENCY=1 instance; response expected one cycle later
    task automatic txn1(input string tag, input logic f, input logic [2:0] t,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_d, input logic exp_m);
        @(negedge clk);
        v1 = 1'b1; f1 = f; t1 = t; a1 = a; d1 = d;
        chk({tag, " ready"}, {31'b0, rdy1}, 32'd1);
        @(negedge clk);
        v1 = 1'b0;
        chk({tag, " valid"}, {31'b0, rv1}, 32'd1);
        chk({tag, " data"}, rd1, exp_d);
        chk({tag, " misaligned"}, {31'b0, rm1}, {31'b0, exp_m});
    endtask

    // One request on the LATENCY=3 instance with a bounded wait for the response
    task automatic txn3(input string tag, input logic f, input logic [2:0] t,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_d);
        int n;
        @(negedge clk);
        v3 = 1'b1; f3 = f; t3 = t; a3 = a; d3 = d;
        chk({tag, " ready"}, {31'b0, rdy3}, 32'd1);
        n = 0;
        do begin
            @(negedge clk);
            v3 = 1'b0;
            n++;
        end while (!rv3 && n < 10);
        chk({tag, " latency"}, n, 32'd3);
        chk({tag, " data"}, rd3, exp_d);
    endtask

    initial begin
        v1 = 0; f1 = 0; t1 = 0; a1 = 0; d1 = 0;
        v3 = 0; f3 = 0; t3 = 0; a3 = 0; d3 = 0;
        rst1 = 1'b1;
        rst3 = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst ready", {31'b0, rdy1}, 32'd0);
        chk("rst valid", {31'b0, rv1}, 32'd0);
        chk("rst data", rd1, 32'h0);
        chk("rst misaligned", {31'b0, rm1}, 32'd0);
        rst1 = 1'b0;
        rst3 = 1'b0;
        @(negedge clk);
        chk("post-rst ready", {31'b0, rdy1}, 32'd1);
        chk("post-rst idle valid", {31'b0, rv1}, 32'd0);

        // Word store and load
        txn1("sw 100", M_XWR, MT_W, 32'h100, 32'hDEADBEEF, 32'h0, 1'b0);
        txn1("lw 100", M_XRD, MT_W, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0);
        @(negedge clk);
        chk("pulse ends", {31'b0, rv1}, 32'd0);
        chk("data holds", rd1, 32'hDEADBEEF);

        // Byte and halfword with extension
        txn1("sb 101", M_XWR, MT_B, 32'h101, 32'h00000080, 32'h0, 1'b0);
        txn1("lb 101", M_XRD, MT_B, 32'h101, 32'h0, 32'hFFFFFF80, 1'b0);
        txn1("lbu 101", M_XRD, MT_BU, 32'h101, 32'h0, 32'h00000080, 1'b0);
        txn1("lh 100", M_XRD, MT_H, 32'h100, 32'h0, 32'hFFFF80EF, 1'b0);
        txn1("lhu 102", M_XRD, MT_HU, 32'h102, 32'h0, 32'h0000DEAD, 1'b0);

        // Misalignment: no access, zero data
        txn1("lw 102 mis", M_XRD, MT_W, 32'h102, 32'h0, 32'h0, 1'b1);
        txn1("sh 103 mis", M_XWR, MT_H, 32'h103, 32'hFFFFFFFF, 32'h0, 1'b1);
        txn1("lw 100 after mis", M_XRD, MT_W, 32'h100, 32'h0, 32'hDEAD80EF, 1'b0);

        // Unsupported types act as words; upper lanes of H and B stores
        txn1("lw typ0", M_XRD, 3'd0, 32'h100, 32'h0, 32'hDEAD80EF, 1'b0);
        txn1("sh 102", M_XWR, MT_H, 32'h102, 32'hBEEF1234, 32'h0, 1'b0);
        txn1("lw after sh", M_XRD, MT_W, 32'h100, 32'h0, 32'h123480EF, 1'b0);
        txn1("sb 103", M_XWR, MT_B, 32'h103, 32'h000001CC, 32'h0, 1'b0);
        txn1("lw typ7", M_XRD, 3'd7, 32'h100, 32'h0, 32'hCC3480EF, 1'b0);
        txn1("lw typ4 mis", M_XRD, 3'd4, 32'h101, 32'h0, 32'h0, 1'b1);
        txn1("lb 103", M_XRD, MT_B, 32'h103, 32'h0, 32'hFFFFFFCC, 1'b0);

        // Address wrap at DEPTH words
        txn1("sw 1000", M_XWR, MT_W, 32'h1000, 32'h12345678, 32'h0, 1'b0);
        txn1("lw 0 wrap", M_XRD, MT_W, 32'h0, 32'h0, 32'h12345678, 1'b0);
        txn1("lw 1100 wrap", M_XRD, MT_W, 32'h1100, 32'h0, 32'hCC3480EF, 1'b0);

        // LATENCY=3 timing with a held request (back-to-back accept in RESP)
        @(negedge clk);
        v3 = 1'b1; f3 = M_XWR; t3 = MT_W; a3 = 32'h0; d3 = 32'h11111111;
        chk("l3 c10 ready", {31'b0, rdy3}, 32'd1);
        @(negedge clk);
        f3 = M_XRD; d3 = 32'h0;  // changed while not ready: must be ignored
        chk("l3 c11 ready", {31'b0, rdy3}, 32'd0);
        chk("l3 c11 valid", {31'b0, rv3}, 32'd0);
        @(negedge clk);
        chk("l3 c12 ready", {31'b0, rdy3}, 32'd0);
        chk("l3 c12 valid", {31'b0, rv3}, 32'd0);
        @(negedge clk);
        chk("l3 c13 valid", {31'b0, rv3}, 32'd1);
        chk("l3 c13 store data", rd3, 32'h0);
        chk("l3 c13 ready", {31'b0, rdy3}, 32'd1);
        @(negedge clk);
        v3 = 1'b0;
        chk("l3 c14 valid", {31'b0, rv3}, 32'd0);
        chk("l3 c14 ready", {31'b0, rdy3}, 32'd0);
        @(negedge clk);
        chk("l3 c15 valid", {31'b0, rv3}, 32'd0);
        @(negedge clk);
        chk("l3 c16 valid", {31'b0, rv3}, 32'd1);
        chk("l3 c16 data", rd3, 32'h11111111);
        @(negedge clk);
        chk("l3 c17 valid", {31'b0, rv3}, 32'd0);
        chk("l3 c17 data holds", rd3, 32'h11111111);
        chk("l3 c17 ready", {31'b0, rdy3}, 32'd1);

        // Reset in BUSY drops a pending store
        txn3("l3 sw 200", M_XWR, MT_W, 32'h200, 32'h5A5A5A5A, 32'h0);
        txn3("l3 lw 200", M_XRD, MT_W, 32'h200, 32'h0, 32'h5A5A5A5A);
        @(negedge clk);
        v3 = 1'b1; f3 = M_XWR; t3 = MT_W; a3 = 32'h200; d3 = 32'hAAAA5555;
        chk("rst6 accept ready", {31'b0, rdy3}, 32'd1);
        @(negedge clk);
        v3 = 1'b0;
        chk("rst6 busy ready", {31'b0, rdy3}, 32'd0);
        #1 rst3 = 1'b1;
        #1;
        chk("rst6 async ready", {31'b0, rdy3}, 32'd0);
        chk("rst6 async valid", {31'b0, rv3}, 32'd0);
        chk("rst6 async data", rd3, 32'h0);
        chk("rst6 async misaligned", {31'b0, rm3}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst3 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rst6 no response", {31'b0, rv3}, 32'd0);
        end
        txn3("rst6 lw 200", M_XRD, MT_W, 32'h200, 32'h0, 32'h5A5A5A5A);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
